// File: rtl/iobuffer_fifo_ctrl.sv
// Streaming FIFO controller around a 1-cycle registered-read dual-port RAM.
// Owns pointers and occupancy; a 2-entry output stage hides the RAM read latency.
module iobuffer_fifo_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned ABITS = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ABITS+1:0] level,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_write_en,
  output logic [ABITS-1:0] ram_waddr,
  output logic [ABITS-1:0] ram_raddr,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int unsigned CW = ABITS + 1;
  localparam int unsigned LW = ABITS + 2;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [ABITS-1:0] wptr, wptr_nxt;
  logic [ABITS-1:0] rptr, rptr_nxt;
  logic [CW-1:0]    mem_count, mem_count_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             out_valid_nxt;
  logic             skid_valid, skid_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [WIDTH-1:0] skid_data, skid_data_nxt;
  logic [LW-1:0]    level_nxt;
  logic [1:0]       stage_occ;
  logic             push, pop, rd_issue;

  assign in_ready     = !flush && (mem_count != DEPTH_CNT);
  assign full         = (mem_count == DEPTH_CNT);
  assign empty        = (level == '0);
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign ram_din      = in_data;
  assign ram_write_en = push;
  assign ram_waddr    = wptr;
  assign ram_raddr    = rptr;

  // Issue a read only if the output stage still has room after this cycle's pop.
  assign stage_occ = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend);
  assign rd_issue  = !flush && (mem_count != '0) && ((stage_occ - 2'(pop)) < 2'd2);

  always_comb begin
    wptr_nxt       = wptr;
    rptr_nxt       = rptr;
    mem_count_nxt  = mem_count;
    rd_pend_nxt    = 1'b0;
    out_valid_nxt  = out_valid;
    skid_valid_nxt = skid_valid;
    out_data_nxt   = out_data;
    skid_data_nxt  = skid_data;

    if (flush) begin
      wptr_nxt       = '0;
      rptr_nxt       = '0;
      mem_count_nxt  = '0;
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else begin
      if (push)     wptr_nxt = wptr + ABITS'(1);
      if (rd_issue) rptr_nxt = rptr + ABITS'(1);
      case ({push, rd_issue})
        2'b10:   mem_count_nxt = mem_count + CW'(1);
        2'b01:   mem_count_nxt = mem_count - CW'(1);
        default: mem_count_nxt = mem_count;
      endcase
      rd_pend_nxt = rd_issue;

      // Output stage: skid drains into out first so ordering stays strict.
      if (pop && skid_valid) begin
        out_data_nxt = skid_data;
        if (rd_pend) skid_data_nxt  = ram_dout;
        else         skid_valid_nxt = 1'b0;
      end else if (!out_valid || pop) begin
        if (rd_pend) begin
          out_data_nxt  = ram_dout;
          out_valid_nxt = 1'b1;
        end else begin
          out_valid_nxt = 1'b0;
        end
      end else if (rd_pend) begin
        skid_data_nxt  = ram_dout;
        skid_valid_nxt = 1'b1;
      end
    end

    level_nxt = LW'(mem_count_nxt) + LW'(rd_pend_nxt) + LW'(out_valid_nxt) + LW'(skid_valid_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_count  <= '0;
      rd_pend    <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
      level      <= '0;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      mem_count  <= mem_count_nxt;
      rd_pend    <= rd_pend_nxt;
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      out_data   <= out_data_nxt;
      skid_data  <= skid_data_nxt;
      level      <= level_nxt;
    end
  end

endmodule

// File: tb/tb_iobuffer_fifo_ctrl.sv
// Bench for iobuffer_fifo_ctrl: directed and random traffic checked against a queue model.
module tb_iobuffer_fifo_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ABITS = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ABITS+1:0] level;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] ram_din;
  logic             ram_write_en;
  logic [ABITS-1:0] ram_waddr;
  logic [ABITS-1:0] ram_raddr;
  logic [WIDTH-1:0] ram_dout;

  logic [WIDTH-1:0] ram [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  // Model: contents in order, plus the edge index at which each word was pushed.
  logic [WIDTH-1:0] q [$];
  int               qt [$];
  int               cyc = 0;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] held;

  iobuffer_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .empty(empty), .full(full),
    .ram_din(ram_din), .ram_write_en(ram_write_en),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Behavioural iobuffer RAM with registered read.
  always @(posedge clock) begin
    if (ram_write_en) ram[ram_waddr] <= ram_din;
    ram_dout <= ram[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    qt.delete();
    hold_pending = 1'b0;
  endtask

  // One clock: drive at negedge, check pre-edge outputs, then advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic fl, output logic acc);
    logic hs_in, hs_out, exp_ov;
    @(negedge clock);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    exp_ov = (q.size() > 0) && ((cyc - qt[0]) >= 2);
    check("level", 32'(level), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (hold_pending) check("out_data_hold", 32'(out_data), 32'(held));
    if (fl) check("in_ready_flush", 32'(in_ready), 32'd0);
    else if (q.size() < DEPTH) check("in_ready", 32'(in_ready), 32'd1);
    else if (q.size() == DEPTH + 2) check("in_ready_full", 32'(in_ready), 32'd0);
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    if (hs_out && q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
    hold_pending = out_valid && !out_ready && !fl;
    held = out_data;
    acc = hs_in;
    @(posedge clock);
    cyc++;
    if (fl) begin
      model_clear();
    end else begin
      if (hs_out && q.size() > 0) begin
        void'(q.pop_front());
        void'(qt.pop_front());
      end
      if (hs_in) begin
        q.push_back(d);
        qt.push_back(cyc);
      end
    end
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while (q.size() > 0 && n < 2000) begin
      step(1'b0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic             acc;
    logic [WIDTH-1:0] nxt;
    int               pushed, n;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clock); reset = 1'b0;

    // Single word latency.
    step(1'b1, 16'h1111, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    #2;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", 32'(out_data), 32'h1111);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    #2;
    check("lat_empty", 32'(empty), 32'd1);

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 256; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, acc);
    #2;
    check("fill_level", 32'(level), 32'd256);
    check("fill_out_data", 32'(out_data), 32'h0000);
    check("fill_not_full", 32'(full), 32'd0);
    step(1'b1, 16'h0100, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0101, 1'b0, 1'b0, acc);
    @(negedge clock); in_valid = 1'b1; #1;
    check("full_flag", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(level), 32'd258);

    // Streaming from full.
    nxt = 16'h0102;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, nxt, 1'b1, 1'b0, acc);
      if (acc) nxt = nxt + 16'd1;
    end
    drain();

    // Backpressure with toggling out_ready.
    pushed = 0; n = 0; nxt = 16'h4000;
    while ((pushed < 64 || q.size() > 0) && n < 1000) begin
      step(pushed < 64, nxt, n[0], 1'b0, acc);
      if (acc) begin pushed++; nxt = nxt + 16'd1; end
      n++;
    end
    check("bp_pushed", 32'(pushed), 32'd64);
    check("bp_drained", 32'(q.size()), 32'd0);

    // Random traffic, enough words to wrap both pointers.
    pushed = 0; n = 0;
    while (pushed < 600 && n < 6000) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) pushed++;
      n++;
    end
    check("rand_pushed", 32'(pushed), 32'd600);
    drain();

    // Flush at level 10 with a simultaneous push.
    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(16'h7000 + i), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("pre_flush_level", 32'(level), 32'd10);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, acc);
    #2;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h5000 + i), 1'b1, 1'b0, acc);
    drain();

    // Async reset mid-stream.
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h6000 + i), 1'b0, 1'b0, acc);
    @(negedge clock); in_valid = 1'b0; #2;
    reset = 1'b1; #1;
    check("areset_level", 32'(level), 32'd0);
    check("areset_empty", 32'(empty), 32'd1);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock); reset = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h2000 + i), 1'b1, 1'b0, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
